// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared state encoding and grant helpers for the DRAM port arbiter
package dram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    localparam int MAX_REQ = 8;

    function automatic logic [2:0] onehot_to_index(input logic [MAX_REQ-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (v[i]) idx = idx | 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: first active requester scanning upward from rrPtr, modulo NUM_REQ
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rrPtr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] low;

    // Rotate so rrPtr sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot    = NUM_REQ'({req, req} >> rrPtr);
    assign low    = rot & (~rot + NUM_REQ'(1));
    assign winner = NUM_REQ'(({low, low} << rrPtr) >> NUM_REQ);
    assign any    = |req;

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin owner of the single DRAM port with optional burst lock
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         reqRead,
    input  logic [NUM_REQ-1:0]         reqWrite,
    input  logic [NUM_REQ-1:0]         reqLock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddress,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqWriteData,
    output logic [DATA_WIDTH-1:0]      reqReadData,
    output logic [NUM_REQ-1:0]         reqValid,
    output logic [NUM_REQ-1:0]         grant,
    output logic [ADDR_WIDTH-1:0]      dramAddress,
    output logic [DATA_WIDTH-1:0]      dramWriteData,
    output logic                       dramWriteEnable,
    output logic                       dramReadEnable,
    input  logic [DATA_WIDTH-1:0]      dramReadData,
    input  logic                       dramValid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   rrPtr;
    logic [IDX_W-1:0]   gIdx;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] pickWin;
    logic               pickAny;
    logic               ownActive;
    logic               ownLock;
    logic               ownWrite;
    logic               busy;

    assign active    = reqRead | reqWrite;
    assign ownActive = |(active & grant);
    assign ownLock   = |(reqLock & grant);
    assign ownWrite  = |(reqWrite & grant);
    assign busy      = state == BUSY;
    assign gIdx      = IDX_W'(onehot_to_index(MAX_REQ'(grant)));

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (active),
        .rrPtr  (rrPtr),
        .winner (pickWin),
        .any    (pickAny)
    );

    // A write wins over a read when the owner raises both.
    assign dramWriteEnable = busy & ownWrite;
    assign dramReadEnable  = busy & |(reqRead & grant) & ~ownWrite;
    assign reqValid        = (busy && dramValid && ownActive) ? grant : '0;
    assign reqReadData     = dramReadData;

    // Route the owner's address and write data to the DRAM only while an access is live.
    always_comb begin
        dramAddress   = '0;
        dramWriteData = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (busy && grant[i]) begin
                dramAddress   = reqAddress[i*ADDR_WIDTH +: ADDR_WIDTH];
                dramWriteData = reqWriteData[i*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    // Ownership FSM: arbitrate in IDLE, run one access in BUSY, keep a locked owner in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            rrPtr <= '0;
        end else begin
            case (state)
                IDLE: if (pickAny) begin
                    grant <= pickWin;
                    state <= BUSY;
                end
                BUSY: if (!ownActive) begin
                    grant <= '0;
                    state <= IDLE;
                end else if (dramValid) begin
                    rrPtr <= (gIdx == IDX_W'(NUM_REQ-1)) ? '0 : gIdx + IDX_W'(1);
                    state <= ownLock ? HOLD : IDLE;
                    grant <= ownLock ? grant : '0;
                end
                HOLD: if (ownActive) begin
                    state <= BUSY;
                end else if (!ownLock) begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed and randomized checks against a round-robin ownership model
module tb_dram_port_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    rd = '0, wr = '0, lk = '0;
    logic [AW-1:0]   a [N];
    logic [DW-1:0]   d [N];
    logic [N*AW-1:0] reqAddress;
    logic [N*DW-1:0] reqWriteData;
    logic [DW-1:0]   reqReadData;
    logic [N-1:0]    reqValid, grant;
    logic [AW-1:0]   dramAddress;
    logic [DW-1:0]   dramWriteData;
    logic            dramWriteEnable, dramReadEnable;
    logic [DW-1:0]   dramReadData = '0;
    logic            dramValid = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int ptr = 0;
    int reissue = -1;
    bit cont = 1'b0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqAddress[i*AW +: AW]   = a[i];
            reqWriteData[i*DW +: DW] = d[i];
        end
    end

    dram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .reqRead(rd), .reqWrite(wr), .reqLock(lk),
        .reqAddress(reqAddress), .reqWriteData(reqWriteData),
        .reqReadData(reqReadData), .reqValid(reqValid), .grant(grant),
        .dramAddress(dramAddress), .dramWriteData(dramWriteData),
        .dramWriteEnable(dramWriteEnable), .dramReadEnable(dramReadEnable),
        .dramReadData(dramReadData), .dramValid(dramValid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] act, input int p);
        for (int k = 0; k < N; k++)
            if (act[IW'((p + k) % N)]) return (p + k) % N;
        return -1;
    endfunction

    task automatic txn(input int own, input int lat, input logic [DW-1:0] rdata);
        int e;
        logic [N-1:0] m;
        logic w, r;
        e = (own >= 0) ? own : pick(rd | wr, ptr);
        m = N'(1) << e;
        w = |(wr & m);
        r = |(rd & m) & ~w;
        @(negedge clk);
        if (reissue >= 0) begin
            rd = rd | (N'(1) << reissue);
            reissue = -1;
        end
        #1;
        chk("grant", grant, m);
        for (int c = 0; c < lat; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk("we", dramWriteEnable, w);
            chk("re", dramReadEnable, r);
            chk("addr", dramAddress, a[IW'(e)]);
            if (w) chk("wdata", dramWriteData, d[IW'(e)]);
            chk("no_valid_busy", reqValid, {N{1'b0}});
        end
        @(negedge clk);
        dramValid = 1'b1;
        dramReadData = rdata;
        #1;
        chk("reqValid", reqValid, m);
        chk("rdata", reqReadData, rdata);
        @(negedge clk);
        dramValid = 1'b0;
        rd = rd & ~m;
        wr = wr & ~m;
        ptr = (e + 1) % N;
        if (cont) reissue = e;
        #1;
        chk("valid_one_cycle", reqValid, {N{1'b0}});
        chk("grant_after", grant, ((lk & m) != 0) ? m : {N{1'b0}});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd = '0;
        wr = '0;
        lk = '0;
        dramValid = 1'b1;
        ptr = 0;
        #1;
        chk("rst_grant", grant, {N{1'b0}});
        chk("rst_we", dramWriteEnable, 1'b0);
        chk("rst_re", dramReadEnable, 1'b0);
        chk("rst_addr", dramAddress, {AW{1'b0}});
        chk("rst_valid", reqValid, {N{1'b0}});
        @(negedge clk);
        dramValid = 1'b0;
        #1;
        chk("rst_idle", grant, {N{1'b0}});
    endtask

    initial begin
        int last;
        logic [1:0] rw;
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        @(negedge clk);
        a[1] = 32'h100;
        rd = 4'b0010;
        txn(-1, 3, 32'hDEADBEEF);

        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) a[i] = $urandom;
        rd = 4'b1111;
        cont = 1'b1;
        for (int i = 0; i < 6; i++) txn(-1, $urandom_range(1, 3), $urandom);
        cont = 1'b0;
        for (int i = 0; i < 4; i++) txn(-1, 1, $urandom);

        @(negedge clk);
        lk = 4'b0001;
        a[0] = 32'h0;
        d[0] = 32'd1;
        wr = 4'b0001;
        txn(-1, 2, $urandom);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            a[1] = 32'h200;
            rd = rd | 4'b0010;
            #1;
            chk("hold_grant", grant, 4'b0001);
            chk("hold_we", dramWriteEnable, 1'b0);
            a[0] = 32'(4 * k);
            d[0] = 32'(k + 1);
            wr = wr | 4'b0001;
            txn(0, $urandom_range(1, 3), $urandom);
        end
        @(negedge clk);
        lk = '0;
        @(negedge clk);
        #1;
        chk("unlock_idle", grant, {N{1'b0}});
        txn(-1, 2, $urandom);

        @(negedge clk);
        a[2] = 32'h40;
        d[2] = 32'h55;
        rd = 4'b0100;
        wr = 4'b0100;
        txn(-1, 2, $urandom);

        @(negedge clk);
        rd = 4'b0100;
        @(negedge clk);
        #1;
        chk("drop_grant", grant, 4'b0100);
        chk("drop_re", dramReadEnable, 1'b1);
        @(negedge clk);
        rd = '0;
        #1;
        chk("drop_re0", dramReadEnable, 1'b0);
        @(negedge clk);
        dramValid = 1'b1;
        #1;
        chk("drop_grant0", grant, {N{1'b0}});
        chk("drop_novalid", reqValid, {N{1'b0}});
        @(negedge clk);
        dramValid = 1'b0;

        @(negedge clk);
        dramValid = 1'b1;
        #1;
        chk("spur_valid", reqValid, {N{1'b0}});
        @(negedge clk);
        dramValid = 1'b0;
        #1;
        chk("spur_grant", grant, {N{1'b0}});

        @(negedge clk);
        a[3] = $urandom;
        rd = 4'b1000;
        @(negedge clk);
        #1;
        chk("busy3", grant, 4'b1000);
        do_reset();
        @(negedge clk);
        rd = 4'b1010;
        txn(-1, 1, $urandom);
        txn(-1, 1, $urandom);

        last = (ptr + N - 1) % N;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                m = N'(1) << i;
                if (i != last && ((rd | wr) & m) == 0 && $urandom_range(0, 1) == 1) begin
                    rw = 2'($urandom_range(1, 3));
                    rd = rw[0] ? (rd | m) : rd;
                    wr = rw[1] ? (wr | m) : wr;
                    a[i] = $urandom;
                    d[i] = $urandom;
                end
            end
            if ((rd | wr) == 0) begin
                rd = N'(1) << ((last + 1) % N);
                a[IW'((last + 1) % N)] = $urandom;
            end
            txn(-1, $urandom_range(1, 4), $urandom);
            last = (ptr + N - 1) % N;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
